integer_datapath_pipe: RTL

//  Parametrised two-stage successor of the integer datapath: register file, S-operand mux (reg or DS) and ALU.

---
 rtl/integer_datapath_pipe.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/integer_datapath_pipe.sv
// Two-stage integer datapath: RD stage reads the register file and selects S, EX stage runs the ALU,
// registers flags and writes back. Define INTEGER_DATAPATH_FWD_EN to bypass the EX result into RD reads.
`timescale 1ns/1ps
module integer_datapath_pipe #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              In_Valid,
  input  logic              Hold,
  input  logic              W_En,
  input  logic [ADDR_W-1:0] W_Adr,
  input  logic [ADDR_W-1:0] R_Adr,
  input  logic [ADDR_W-1:0] S_Adr,
  input  logic              S_Sel,
  input  logic [DATA_W-1:0] DS,
  input  logic [3:0]        ALU_OP,
  output logic [DATA_W-1:0] Reg_Out,
  output logic [DATA_W-1:0] Alu_Out,
  output logic              Out_Valid,
  output logic              N,
  output logic              Z,
  output logic              C
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [DATA_W:0] ONE = {{DATA_W{1'b0}}, 1'b1};

  // Handshake: an op is accepted on a rising edge where In_Valid=1 and Hold=0; its result is
  // presented with Out_Valid=1 two edges later and stays until the next non-held edge.

  logic [DATA_W-1:0] regs [NREGS];

  logic              ex_valid;
  logic              ex_wen;
  logic [ADDR_W-1:0] ex_wadr;
  logic [3:0]        ex_op;
  logic [DATA_W-1:0] ex_r;
  logic [DATA_W-1:0] ex_s;

  logic [DATA_W-1:0] rd_r;
  logic [DATA_W-1:0] rd_s_reg;
  logic [DATA_W-1:0] rd_s;

  logic [DATA_W-1:0] alu_y;
  logic              alu_c;
  logic [DATA_W:0]   sum;

  // EX-stage ALU
  always_comb begin
    sum   = '0;
    alu_y = '0;
    alu_c = 1'b0;
    case (ex_op)
      4'h0: alu_y = ex_r;
      4'h1: alu_y = ex_s;
      4'h2: begin
        sum   = {1'b0, ex_r} + {1'b0, ex_s};
        alu_y = sum[DATA_W-1:0];
        alu_c = sum[DATA_W];
      end
      4'h3: begin
        sum   = {1'b0, ex_r} + {1'b0, ~ex_s} + ONE;
        alu_y = sum[DATA_W-1:0];
        alu_c = sum[DATA_W];
      end
      4'h4: begin
        sum   = {1'b0, ex_s} + ONE;
        alu_y = sum[DATA_W-1:0];
        alu_c = sum[DATA_W];
      end
      4'h5: begin
        sum   = {1'b0, ex_s} + {1'b0, {DATA_W{1'b1}}};
        alu_y = sum[DATA_W-1:0];
        alu_c = sum[DATA_W];
      end
      4'h6: alu_y = ex_r & ex_s;
      4'h7: alu_y = ex_r | ex_s;
      4'h8: alu_y = ex_r ^ ex_s;
      4'h9: alu_y = ~ex_s;
      4'hA: begin
        alu_y = {ex_s[DATA_W-2:0], 1'b0};
        alu_c = ex_s[DATA_W-1];
      end
      4'hB: begin
        alu_y = {1'b0, ex_s[DATA_W-1:1]};
        alu_c = ex_s[0];
      end
      4'hC: begin
        alu_y = {ex_s[DATA_W-1], ex_s[DATA_W-1:1]};
        alu_c = ex_s[0];
      end
      4'hD: begin
        sum   = {1'b0, ~ex_s} + ONE;
        alu_y = sum[DATA_W-1:0];
        alu_c = sum[DATA_W];
      end
      4'hE: alu_y = '0;
      4'hF: alu_y = '1;
      default: alu_y = '0;
    endcase
  end

  // RD-stage operand read; the bypass covers the register EX writes back at the coming edge
  always_comb begin
    rd_r     = regs[R_Adr];
    rd_s_reg = regs[S_Adr];
`ifdef INTEGER_DATAPATH_FWD_EN
    if (ex_valid && ex_wen && (ex_wadr == R_Adr)) rd_r = alu_y;
    if (ex_valid && ex_wen && (ex_wadr == S_Adr)) rd_s_reg = alu_y;
`endif
    rd_s = S_Sel ? DS : rd_s_reg;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ex_valid <= 1'b0;
      ex_wen   <= 1'b0;
      ex_wadr  <= '0;
      ex_op    <= '0;
      ex_r     <= '0;
      ex_s     <= '0;
    end else if (!Hold) begin
      ex_valid <= In_Valid;
      if (In_Valid) begin
        ex_wen  <= W_En;
        ex_wadr <= W_Adr;
        ex_op   <= ALU_OP;
        ex_r    <= rd_r;
        ex_s    <= rd_s;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      Alu_Out   <= '0;
      Out_Valid <= 1'b0;
      N         <= 1'b0;
      Z         <= 1'b0;
      C         <= 1'b0;
    end else if (!Hold) begin
      Out_Valid <= ex_valid;
      if (ex_valid) begin
        Alu_Out <= alu_y;
        N       <= alu_y[DATA_W-1];
        Z       <= (alu_y == '0);
        C       <= alu_c;
        if (ex_wen) regs[ex_wadr] <= alu_y;
      end
    end
  end

  assign Reg_Out = ex_r;

endmodule
